// File: rtl/cnt_bcd_conv.sv
// cnt_bcd_conv: samples one of two 64-bit count values on request and converts
// it to packed BCD with an iterative shift-add-3 (double-dabble) engine that
// processes one binary bit per clock.
//
// Timing, with the Start edge called E0:
//  - The engine steps on edges E0+1 .. E0+WIDTH.
//  - The result is published at edge E0+WIDTH.
//  - Done is high for the single cycle that follows that edge.
//  - The edge that leaves DONE can accept a new Start. So a Start held high
//    produces back-to-back conversions every WIDTH+1 cycles.
//  - A Start during SHIFT is ignored.
module cnt_bcd_conv #(
   parameter int WIDTH  = 64,
   parameter int DIGITS = 20
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  Slt,
   input  logic [WIDTH-1:0]      Input0,
   input  logic [WIDTH-1:0]      Input1,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Valid,
   output logic                  SltOut,
   output logic [4*DIGITS-1:0]   Bcd
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = 4 * DIGITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t            state_q,    state_d;
   logic [WIDTH-1:0]  shreg_q,    shreg_d;
   logic [BW-1:0]     scratch_q,  scratch_d;
   logic [CW-1:0]     cnt_q,      cnt_d;
   logic [BW-1:0]     bcd_q,      bcd_d;
   logic              slt_lat_q,  slt_lat_d;
   logic              slt_out_q,  slt_out_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              valid_q,    valid_d;
   logic [BW-1:0]     step_s;

   // Apply +3 to every digit that is 5 or more; digits are independent (no carry).
   function automatic logic [BW-1:0] add3_fn(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   // One double-dabble step: adjust digits, then shift in the shift-register MSB.
   always_comb begin
      step_s = (add3_fn(scratch_q) << 1) | {{(BW-1){1'b0}}, shreg_q[WIDTH-1]};
   end

   // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      slt_lat_d = slt_lat_q;
      slt_out_d = slt_out_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      valid_d   = valid_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               shreg_d   = Slt ? Input1 : Input0;
               slt_lat_d = Slt;
               scratch_d = {BW{1'b0}};
               cnt_d     = {CW{1'b0}};
               busy_d    = 1'b1;
               state_d   = ST_SHIFT;
            end else begin
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            scratch_d = step_s;
            shreg_d   = shreg_q << 1;
            cnt_d     = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(WIDTH - 1)) begin
               bcd_d     = step_s;
               slt_out_d = slt_lat_q;
               valid_d   = 1'b1;
               done_d    = 1'b1;
               state_d   = ST_DONE;
            end else begin
               state_d   = ST_SHIFT;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; async active-low reset discards any conversion.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_IDLE;
         shreg_q   <= {WIDTH{1'b0}};
         scratch_q <= {BW{1'b0}};
         cnt_q     <= {CW{1'b0}};
         bcd_q     <= {BW{1'b0}};
         slt_lat_q <= 1'b0;
         slt_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         slt_lat_q <= slt_lat_d;
         slt_out_q <= slt_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
      end
   end

   assign Busy   = busy_q;
   assign Done   = done_q;
   assign Valid  = valid_q;
   assign SltOut = slt_out_q;
   assign Bcd    = bcd_q;

endmodule

// File: tb/tb_cnt_bcd_conv.sv
// Directed testbench for cnt_bcd_conv with hand-computed expected values.
module tb_cnt_bcd_conv;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic        Slt;
   logic [63:0] Input0;
   logic [63:0] Input1;
   logic        Busy;
   logic        Done;
   logic        Valid;
   logic        SltOut;
   logic [79:0] Bcd;

   int total;
   int bad;

   cnt_bcd_conv #(.WIDTH(64), .DIGITS(20)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .Slt    (Slt),
      .Input0 (Input0),
      .Input1 (Input1),
      .Busy   (Busy),
      .Done   (Done),
      .Valid  (Valid),
      .SltOut (SltOut),
      .Bcd    (Bcd)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse Start for one edge (E0); returns #1 after E0.
   task automatic do_start(input logic slt_v);
      Slt   = slt_v;
      Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
   endtask

   // Number of edges until Done is seen high (-1 if the bound expires).
   task automatic wait_done(output int n);
      bit found;
      found = 1'b0;
      n = -1;
      for (int i = 1; i <= 200 && !found; i++) begin
         @(posedge Clk); #1;
         if (Done) begin
            found = 1'b1;
            n = i;
         end
      end
   endtask

   initial begin
      int n;
      int pulses;
      total  = 0;
      bad    = 0;
      Reset  = 1'b0;
      Start  = 1'b0;
      Slt    = 1'b0;
      Input0 = 64'd0;
      Input1 = 64'd0;

      // 1: reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_busy",  {79'd0, Busy},   80'd0);
      chk("rst_done",  {79'd0, Done},   80'd0);
      chk("rst_valid", {79'd0, Valid},  80'd0);
      chk("rst_slt",   {79'd0, SltOut}, 80'd0);
      chk("rst_bcd",   Bcd,             80'd0);
      Reset = 1'b1;
      @(posedge Clk); #1;

      // 2: zero, latency
      Input0 = 64'd0;
      Input1 = 64'd55;
      do_start(1'b0);
      chk("t2_busy", {79'd0, Busy}, 80'd1);
      wait_done(n);
      chk("t2_lat",   80'(n),           80'd64);
      chk("t2_bcd",   Bcd,              80'd0);
      chk("t2_valid", {79'd0, Valid},   80'd1);
      chk("t2_slt",   {79'd0, SltOut},  80'd0);
      chk("t2_busyd", {79'd0, Busy},    80'd1);
      @(posedge Clk); #1;
      chk("t2_done0", {79'd0, Done}, 80'd0);
      chk("t2_idle",  {79'd0, Busy}, 80'd0);

      // 3: 12345 via Input1
      Input0 = 64'd777;
      Input1 = 64'd12345;
      do_start(1'b1);
      wait_done(n);
      chk("t3_lat", 80'(n),          80'd64);
      chk("t3_bcd", Bcd,             80'h12345);
      chk("t3_slt", {79'd0, SltOut}, 80'd1);
      @(posedge Clk); #1;
      chk("t3_width", {79'd0, Done}, 80'd0);

      // 4: all ones
      Input0 = 64'hFFFF_FFFF_FFFF_FFFF;
      do_start(1'b0);
      wait_done(n);
      chk("t4_bcd", Bcd,             80'h18446744073709551615);
      chk("t4_slt", {79'd0, SltOut}, 80'd0);
      @(posedge Clk); #1;

      // 5: changes mid-conversion are ignored
      Input0 = 64'd99;
      do_start(1'b0);
      repeat (9) @(posedge Clk);
      #1;
      Input0 = 64'd7;
      Slt    = 1'b1;
      Start  = 1'b1;
      @(posedge Clk); #1;
      Start  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 140; i++) begin
         @(posedge Clk); #1;
         if (Done) pulses++;
      end
      chk("t5_pulses", 80'(pulses),      80'd1);
      chk("t5_bcd",    Bcd,              80'h99);
      chk("t5_slt",    {79'd0, SltOut},  80'd0);
      chk("t5_idle",   {79'd0, Busy},    80'd0);

      // 6: reset mid-conversion
      Input0 = 64'd500;
      Slt    = 1'b0;
      do_start(1'b0);
      repeat (29) @(posedge Clk);
      #1;
      Reset = 1'b0;
      #1;
      chk("t6_busy",  {79'd0, Busy},  80'd0);
      chk("t6_bcd",   Bcd,            80'd0);
      chk("t6_valid", {79'd0, Valid}, 80'd0);
      repeat (2) @(posedge Clk);
      #1;
      Reset  = 1'b1;
      @(posedge Clk); #1;
      Input0 = 64'd1;
      do_start(1'b0);
      wait_done(n);
      chk("t6_lat", 80'(n), 80'd64);
      chk("t6_bcd1", Bcd,   80'h1);
      @(posedge Clk); #1;

      // 7: Start held high -> back-to-back every 65 cycles
      Input0 = 64'd42;
      Slt    = 1'b0;
      Start  = 1'b1;
      @(posedge Clk); #1;
      wait_done(n);
      chk("t7_lat1", 80'(n), 80'd64);
      chk("t7_bcd1", Bcd,    80'h42);
      Input0 = 64'd43;
      @(posedge Clk); #1;
      Start  = 1'b0;
      chk("t7_rebusy", {79'd0, Busy}, 80'd1);
      wait_done(n);
      chk("t7_lat2", 80'(n + 1), 80'd65);
      chk("t7_bcd2", Bcd,        80'h43);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
